key_expansion: RTL
==================

KEY_EXPANSION -- requirements
Module: key_expansion

Interface
REQ-001 Parameters: none; AES-128 only, 10 rounds, fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request expansion of key; sampled on rising edge of clk.
REQ-005 key  input  128  cipher key, word 0 at [127:96], byte 0 at [127:120]; sampled only with an accepted start.
REQ-006 busy  output  1  high while round keys 1..10 are being generated.
REQ-007 done  output  1  single-cycle pulse when round key 10 has been written.
REQ-008 key_valid  output  1  high while all 11 round keys in the store belong to the last accepted key.
REQ-009 rd_round  input  4  round-key index to read, 0..10.
REQ-010 rd_key  output  128  registered round key for rd_round, same word/byte order as key.

Function
REQ-011 The block SHALL hold an 11-entry x 128-bit round-key store, slot 0 = cipher key, slot r = round key r.
REQ-012 Round transform SHALL be FIPS-197 AES-128: w0' = w0 ^ SubWord(RotWord(w3)) ^ {Rcon[r],24'h0}; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
REQ-013 Rcon[1..10] SHALL be 01,02,04,08,10,20,40,80,1b,36.
REQ-014 SubWord SHALL use the standard AES forward S-box, purely combinational, 4 instances.
REQ-015 FSM states SHALL be IDLE, EXPAND, DONE; reset state IDLE.
REQ-016 IDLE or DONE with start=1 at an edge: slot 0 <= key, round counter <= 1, key_valid <= 0, next state EXPAND.
REQ-017 EXPAND: each edge SHALL write slot[cnt] <= transform(slot[cnt-1], cnt) and increment cnt; exactly one round per cycle.
REQ-018 EXPAND with cnt=10: the edge writes slot 10, enters DONE, sets key_valid <= 1, done <= 1.
REQ-019 done SHALL be high for exactly the one cycle after entry into DONE, then 0.
REQ-020 Latency: start high in cycle 0 -> busy high cycles 1..10, done and key_valid high from cycle 11.
REQ-021 start while in EXPAND SHALL be ignored, with no effect on key, count or store.
REQ-022 start in DONE SHALL restart per REQ-016; slots 1..10 remain stale until overwritten, key_valid stays 0 until the new done.
REQ-023 rd_key SHALL update at each edge to slot[rd_round] as it was before that edge (1-cycle read latency); read-during-write returns old data.
REQ-024 rd_round 11..15 SHALL yield rd_key = 0.
REQ-025 Reads SHALL be allowed in every state; rd_key validity is indicated only by key_valid.
REQ-026 done and a restart start in the same DONE cycle: the restart SHALL be accepted; done still pulses its single cycle.

Reset
REQ-027 rst=1 at an edge SHALL force state IDLE, cnt=0, busy=0, done=0, key_valid=0, rd_key=0, and all 11 slots = 0.
REQ-028 rst SHALL take priority over start and over any in-progress expansion (mid-EXPAND reset aborts; no done).
REQ-029 First start SHALL be accepted at the edge after rst deasserts.

Verification
REQ-030 Key 2b7e151628aed2a6abf7158809cf4f3c, start 1 cycle -> done in cycle 11; rd_round=1 -> a0fafe1788542cb123a339392a6c7605; rd_round=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6; rd_round=0 -> the key.
REQ-031 Key all-zero -> round 1 = 62636363626363636263636362636363; key_valid=1 after done.
REQ-032 Second start pulse in cycle 4 of an expansion -> ignored; done still in cycle 11 with first key's results.
REQ-033 rst asserted in cycle 5 of an expansion -> next cycle busy=0, key_valid=0, rd_key of every slot reads 0; no done pulse.
REQ-034 Start in DONE with new key -> key_valid falls next cycle, rises 11 cycles after start; rd_round=12 always returns 0.

Source files
------------

// File: rtl/key_expansion_if.sv
// Bus bundle for the AES-128 key expansion block: start/key request,
// status flags and the round-key read port.
interface key_expansion_if;
  logic         start;
  logic [127:0] key;
  logic         busy;
  logic         done;
  logic         key_valid;
  logic [3:0]   rd_round;
  logic [127:0] rd_key;

  modport master (
    output start, key, rd_round,
    input  busy, done, key_valid, rd_key
  );

  modport slave (
    input  start, key, rd_round,
    output busy, done, key_valid, rd_key
  );
endinterface

// File: rtl/key_expansion.sv
// AES-128 key expansion: expands a cipher key into an 11 x 128-bit round-key
// store, one round per clock, with a registered read port into the store.
module key_expansion (
  input  logic            clk,
  input  logic            rst,
  key_expansion_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_e;

  // AES forward S-box, byte 0x00 in the most significant position.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    // ~b == 255 - b, so entry b sits at bit offset 8*(255-b)
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_e         state_q, state_d;
  logic [3:0]     cnt_q;
  logic           done_q;
  logic           key_valid_q;
  logic [127:0]   rd_key_q;
  logic [127:0]   slot_q [0:10];

  logic           load;
  logic           step;
  logic [127:0]   prev_rk;
  logic [31:0]    rot_w3;
  logic [31:0]    sub_w3;
  logic [31:0]    w0_d, w1_d, w2_d, w3_d;
  logic [127:0]   round_key_d;

  // Next state and per-cycle control: accept start in IDLE/DONE, step in EXPAND
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = EXPAND;
          load    = 1'b1;
        end
      end
      EXPAND: begin
        step = 1'b1;
        if (cnt_q == 4'd10) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Round transform of the previous round key into round key cnt
  always_comb begin
    prev_rk     = slot_q[cnt_q - 4'd1];
    rot_w3      = {prev_rk[23:0], prev_rk[31:24]};
    sub_w3      = {sbox(rot_w3[31:24]), sbox(rot_w3[23:16]),
                   sbox(rot_w3[15:8]),  sbox(rot_w3[7:0])};
    w0_d        = prev_rk[127:96] ^ sub_w3 ^ {rcon(cnt_q), 24'h0};
    w1_d        = prev_rk[95:64] ^ w0_d;
    w2_d        = prev_rk[63:32] ^ w1_d;
    w3_d        = prev_rk[31:0]  ^ w2_d;
    round_key_d = {w0_d, w1_d, w2_d, w3_d};
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Round counter, status flags, round-key store and registered read port
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      done_q      <= 1'b0;
      key_valid_q <= 1'b0;
      rd_key_q    <= '0;
      for (int unsigned i = 0; i < 11; i++) slot_q[i] <= '0;
    end else begin
      // read sees the store as it was before this edge
      rd_key_q <= (bus.rd_round <= 4'd10) ? slot_q[bus.rd_round] : '0;
      done_q   <= step && (cnt_q == 4'd10);
      if (load) begin
        slot_q[0]   <= bus.key;
        cnt_q       <= 4'd1;
        key_valid_q <= 1'b0;
      end
      if (step) begin
        slot_q[cnt_q] <= round_key_d;
        cnt_q         <= cnt_q + 4'd1;
        if (cnt_q == 4'd10) key_valid_q <= 1'b1;
      end
    end
  end

  assign bus.busy      = (state_q == EXPAND);
  assign bus.done      = done_q;
  assign bus.key_valid = key_valid_q;
  assign bus.rd_key    = rd_key_q;

endmodule
